fma_output_stage: RTL and testbench

// - Final pipeline stage of the single-precision FMA: mirror of the input capture stage at the operand end.
// - Takes the unrounded normalized result {sign, exp, mant+GRS} from the add/normalize stage.
// - Rounds to nearest-even, packs IEEE-754 binary32 and raises status flags.
// - Presents the result downstream over a valid/ready handshake, buffered by a 2-entry skid.

---
 rtl/fma_pkg.sv | 27 ++
 rtl/fma_round_pack.sv | 66 ++++++
 rtl/fma_output_stage.sv | 98 +++++++++
 tb/tb_fma_output_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// rtl/fma_pkg.sv - shared widths, constants and payload types for the FMA output stage
package fma_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int GRS_W    = 3;
    localparam int MANT_W   = 1 + FRAC_W + GRS_W;
    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;
    localparam int IN_EXP_W = 10;
    localparam int RES_W    = 1 + EXP_W + FRAC_W;

    localparam logic [RES_W-1:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
    } flags_t;

    // Packed result plus flags; this is what the main and skid registers hold.
    typedef struct packed {
        logic [RES_W-1:0] result;
        flags_t           flags;
    } payload_t;

endpackage

// File: rtl/fma_round_pack.sv
// rtl/fma_round_pack.sv - combinational round-to-nearest-even, binary32 pack and status flags
module fma_round_pack #(
    parameter int          IN_EXP_W = fma_pkg::IN_EXP_W,
    parameter logic [31:0] QNAN     = fma_pkg::QNAN
) (
    input  logic                          sign,
    input  logic [IN_EXP_W-1:0]           exp_in,
    input  logic [fma_pkg::MANT_W-1:0]    mant,
    input  logic                          is_nan,
    input  logic                          is_inf,
    input  logic                          is_zero,
    output logic [fma_pkg::RES_W-1:0]     result,
    output fma_pkg::flags_t               flags
);
    import fma_pkg::*;

    localparam logic signed [IN_EXP_W:0] EXP_OVF  = (IN_EXP_W + 1)'(EXP_MAX);
    localparam logic signed [IN_EXP_W:0] EXP_ZERO = '0;

    logic                      lsb_bit;
    logic                      guard_bit;
    logic                      round_bit;
    logic                      sticky_bit;
    logic                      round_up;
    logic [MANT_W-GRS_W:0]     mant_sum;
    logic                      carry;
    logic [FRAC_W-1:0]         frac;
    logic signed [IN_EXP_W:0]  exp_r;

    always_comb begin
        lsb_bit    = mant[GRS_W];
        guard_bit  = mant[GRS_W-1];
        round_bit  = mant[GRS_W-2];
        sticky_bit = mant[GRS_W-3];
        round_up   = guard_bit & (round_bit | sticky_bit | lsb_bit);

        mant_sum = {1'b0, mant[MANT_W-1:GRS_W]} + {{(MANT_W-GRS_W){1'b0}}, round_up};
        carry    = mant_sum[MANT_W-GRS_W];
        // A carry out means the significand became 10.000..0: renormalise to 1.0.
        frac     = carry ? '0 : mant_sum[FRAC_W-1:0];
        exp_r    = $signed({exp_in[IN_EXP_W-1], exp_in})
                 + $signed({{IN_EXP_W{1'b0}}, carry});

        result = {sign, exp_r[EXP_W-1:0], frac};
        flags  = '{ovf: 1'b0, unf: 1'b0, inx: guard_bit | round_bit | sticky_bit};

        if (is_nan) begin
            result = QNAN;
            flags  = '0;
        end else if (is_inf) begin
            result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags  = '0;
        end else if (is_zero) begin
            result = {sign, {(RES_W-1){1'b0}}};
            flags  = '0;
        end else if (exp_r >= EXP_OVF) begin
            result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags  = '{ovf: 1'b1, unf: 1'b0, inx: 1'b1};
        end else if (exp_r <= EXP_ZERO) begin
            // No denormal support: anything below the normal range flushes to signed zero.
            result = {sign, {(RES_W-1){1'b0}}};
            flags  = '{ovf: 1'b0, unf: 1'b1, inx: 1'b1};
        end
    end

endmodule

// File: rtl/fma_output_stage.sv
// rtl/fma_output_stage.sv - FMA final stage: round/pack into a main register backed by a one-entry skid
module fma_output_stage #(
    parameter int          IN_EXP_W = fma_pkg::IN_EXP_W,
    parameter logic [31:0] QNAN     = fma_pkg::QNAN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [IN_EXP_W-1:0] in_exp,
    input  logic [26:0]         in_mant,
    input  logic                in_nan,
    input  logic                in_inf,
    input  logic                in_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         result,
    output logic                flag_ovf,
    output logic                flag_unf,
    output logic                flag_inx
);
    import fma_pkg::*;

    payload_t rp_payload;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    logic     out_valid_q, out_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     in_ready_q;
    logic     accept_in;
    logic     accept_out;

    fma_round_pack #(
        .IN_EXP_W (IN_EXP_W),
        .QNAN     (QNAN)
    ) u_round_pack (
        .sign    (in_sign),
        .exp_in  (in_exp),
        .mant    (in_mant),
        .is_nan  (in_nan),
        .is_inf  (in_inf),
        .is_zero (in_zero),
        .result  (rp_payload.result),
        .flags   (rp_payload.flags)
    );

    assign accept_in  = in_valid & in_ready_q;
    assign accept_out = out_valid_q & out_ready;

    // The skid can only be occupied while the main register is held, so the
    // skid never needs to be bypassed when the main register is free.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || accept_out) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_in) begin
                main_d      = rp_payload;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_in) begin
            skid_d       = rp_payload;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = main_q.result;
    assign flag_ovf  = main_q.flags.ovf;
    assign flag_unf  = main_q.flags.unf;
    assign flag_inx  = main_q.flags.inx;

endmodule

// File: tb/tb_fma_output_stage.sv
// tb/tb_fma_output_stage.sv - directed and streaming checks for fma_output_stage
module tb_fma_output_stage;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [26:0] m;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_nan;
    logic        in_inf;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inx;

    int n_checks;
    int n_fail;

    vec_t vt[16];
    vec_t sv[100];

    fma_output_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inx  (flag_inx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_sign = v.s;
        in_exp  = v.e;
        in_mant = v.m;
        in_nan  = v.nan;
        in_inf  = v.inf;
        in_zero = v.zero;
    endtask

    function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [26:0] m,
                                input logic nan, input logic inf, input logic zero,
                                input logic [31:0] res, input logic [2:0] fl);
        vec_t v;
        v.s = s; v.e = e; v.m = m; v.nan = nan; v.inf = inf; v.zero = zero;
        v.res = res; v.fl = fl;
        return v;
    endfunction

    // Independent integer-arithmetic reference: returns {result, ovf, unf, inx}.
    function automatic logic [34:0] model(input vec_t v);
        int unsigned keep;
        int unsigned rem;
        int          ee;
        logic        inexact;
        if (v.nan)  return {32'h7FC00000, 3'b000};
        if (v.inf)  return {v.s, 8'hFF, 23'h0, 3'b000};
        if (v.zero) return {v.s, 31'h0, 3'b000};
        keep    = 32'(v.m) >> 3;
        rem     = 32'(v.m) & 32'd7;
        ee      = int'($signed(v.e));
        inexact = (rem != 0);
        if (rem > 4 || (rem == 4 && keep[0])) keep = keep + 1;
        if (keep == 32'h0100_0000) begin
            keep = keep >> 1;
            ee   = ee + 1;
        end
        if (ee >= 255) return {v.s, 8'hFF, 23'h0, 3'b101};
        if (ee <= 0)   return {v.s, 31'h0, 3'b011};
        return {v.s, ee[7:0], keep[22:0], 2'b00, inexact};
    endfunction

    initial begin
        logic [34:0]  mres;
        logic [31:0]  got[$];
        logic         acc;
        int           e_int;
        int           sel;

        n_checks = 0;
        n_fail   = 0;

        vt[0]  = mk(0, 10'd127,  27'h4000000, 0, 0, 0, 32'h3F800000, 3'b000);
        vt[1]  = mk(0, 10'd127,  27'h4000004, 0, 0, 0, 32'h3F800000, 3'b001);
        vt[2]  = mk(0, 10'd127,  27'h400000C, 0, 0, 0, 32'h3F800002, 3'b001);
        vt[3]  = mk(0, 10'd127,  27'h7FFFFFC, 0, 0, 0, 32'h40000000, 3'b001);
        vt[4]  = mk(0, 10'd254,  27'h7FFFFFC, 0, 0, 0, 32'h7F800000, 3'b101);
        vt[5]  = mk(1, 10'd0,    27'h4000000, 0, 0, 0, 32'h80000000, 3'b011);
        vt[6]  = mk(0, 10'd127,  27'h4000000, 1, 1, 0, 32'h7FC00000, 3'b000);
        vt[7]  = mk(1, 10'd127,  27'h4000006, 0, 1, 1, 32'hFF800000, 3'b000);
        vt[8]  = mk(1, 10'd5,    27'h4000007, 0, 0, 1, 32'h80000000, 3'b000);
        vt[9]  = mk(0, 10'd1,    27'h4000001, 0, 0, 0, 32'h00800000, 3'b001);
        vt[10] = mk(0, 10'h3FD,  27'h4000000, 0, 0, 0, 32'h00000000, 3'b011);
        vt[11] = mk(0, 10'h12C,  27'h4000000, 0, 0, 0, 32'h7F800000, 3'b101);
        vt[12] = mk(0, 10'd254,  27'h7FFFFFB, 0, 0, 0, 32'h7F7FFFFF, 3'b001);
        vt[13] = mk(0, 10'd127,  27'h4000006, 0, 0, 0, 32'h3F800001, 3'b001);
        vt[14] = mk(0, 10'd0,    27'h7FFFFFC, 0, 0, 0, 32'h00800000, 3'b001);
        vt[15] = mk(1, 10'd128,  27'h5555554, 0, 0, 0, 32'hC02AAAAA, 3'b001);

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(vt[0]);
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset result",    result,         32'h0);
        check("reset flags",     32'({flag_ovf, flag_unf, flag_inx}), 32'd0);
        rst = 1'b0;

        // Table: one vector at a time, result must appear exactly one cycle after accept.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle out_valid v%0d", i), 32'(out_valid), 32'd0);
            drive(vt[i]);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("latency out_valid v%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("result v%0d", i), result, vt[i].res);
            check($sformatf("flags v%0d", i), 32'({flag_ovf, flag_unf, flag_inx}), 32'(vt[i].fl));
        end

        // Backpressure: A to main, B to skid, C stalled for the duration.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(vt[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("bp in_ready after A", 32'(in_ready), 32'd1);
        drive(vt[2]);
        @(posedge clk);
        #1;
        check("bp in_ready after B", 32'(in_ready), 32'd0);
        check("bp holds A", result, vt[0].res);
        drive(vt[3]);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("bp stall in_ready", 32'(in_ready), 32'd0);
            check("bp stall out_valid", 32'(out_valid), 32'd1);
            check("bp stall result", result, vt[0].res);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) got.push_back(result);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        check("bp result count", 32'(got.size()), 32'd3);
        if (got.size() >= 3) begin
            check("bp order 0", got[0], vt[0].res);
            check("bp order 1", got[1], vt[2].res);
            check("bp order 2", got[2], vt[3].res);
        end

        // Full-rate streaming against the reference model.
        for (int i = 0; i < 100; i++) begin
            e_int = int'($urandom_range(0, 270)) - 5;
            sel   = int'($urandom_range(0, 19));
            sv[i].s    = 1'($urandom);
            sv[i].e    = e_int[9:0];
            sv[i].m    = {1'b1, 26'($urandom)};
            sv[i].nan  = (sel == 0);
            sv[i].inf  = (sel == 1);
            sv[i].zero = (sel == 2);
            mres       = model(sv[i]);
            sv[i].res  = mres[34:3];
            sv[i].fl   = mres[2:0];
        end
        out_ready = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                check($sformatf("stream out_valid %0d", i - 1), 32'(out_valid), 32'd1);
                check($sformatf("stream result %0d", i - 1), result, sv[i-1].res);
                check($sformatf("stream flags %0d", i - 1),
                      32'({flag_ovf, flag_unf, flag_inx}), 32'(sv[i-1].fl));
            end
            check($sformatf("stream in_ready %0d", i), 32'(in_ready), 32'd1);
            if (i < 100) begin
                drive(sv[i]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end

        // Reset with the skid full: nothing stale may ever come out.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(vt[13]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(vt[15]);
        @(posedge clk);
        #1;
        check("rst pre skid full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst result",    result,         32'h0);
        check("rst flags",     32'({flag_ovf, flag_unf, flag_inx}), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-rst no stale %0d", k), 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
